// File: rtl/prog_uart_loader.sv
// Loads a little-endian word stream from an 8N1 UART into instruction memory.
// The core is held in reset while a load is in progress.
module prog_uart_loader #(
    parameter int          MEM_AW   = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_i,
    input  logic              uart_rx_i,
    input  logic [15:0]       clks_per_bit_i,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;

    state_e            state_q, state_d;
    rx_e               rx_q, rx_d;
    logic [2:0]        prog_s_q, rx_s_q;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d, maddr_q, maddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d, done_q, done_d, ferr_q, ferr_d;

    logic        rx_s, prog_rise, rx_fall;
    logic [15:0] eff_cpb, half_cpb;
    logic [31:0] full_word;

    // Stage [1] is the synchronized signal; stage [2] is its one-cycle delay for edge detection.
    assign rx_s      = rx_s_q[1];
    assign prog_rise = prog_s_q[1] & ~prog_s_q[2];
    assign rx_fall   = ~rx_s_q[1] & rx_s_q[2];
    assign eff_cpb   = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
    assign half_cpb  = eff_cpb >> 1;
    assign full_word = {shreg_q, word_q[31:8]};

    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        addr_d  = addr_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        ferr_d  = ferr_q;

        if (state_q != LOAD) begin
            rx_d  = RX_IDLE;
            cnt_d = '0;
            if (prog_rise) begin
                state_d = LOAD;
                addr_d  = '0;
                bcnt_d  = '0;
                done_d  = 1'b0;
                ferr_d  = 1'b0;
            end
        end else begin
            unique case (rx_q)
                RX_IDLE: if (rx_fall) begin
                    rx_d  = RX_START;
                    cnt_d = '0;
                end
                RX_START: if (cnt_q == half_cpb - 16'd1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rx_d  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                RX_DATA: if (cnt_q == eff_cpb - 16'd1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                RX_STOP: if (cnt_q == eff_cpb - 16'd1) begin
                    cnt_d = '0;
                    rx_d  = RX_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        word_d = full_word;
                        bcnt_d = bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            if (full_word == END_WORD) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = full_word;
                                maddr_d = addr_q;
                                addr_d  = addr_q + 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                default: rx_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rx_q     <= RX_IDLE;
            prog_s_q <= 3'b000;
            rx_s_q   <= 3'b111;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            word_q   <= '0;
            bcnt_q   <= '0;
            addr_q   <= '0;
            maddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_q     <= rx_d;
            prog_s_q <= {prog_s_q[1:0], prog_i};
            rx_s_q   <= {rx_s_q[1:0], uart_rx_i};
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            word_q   <= word_d;
            bcnt_q   <= bcnt_d;
            addr_q   <= addr_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q == LOAD);
    assign core_rst_no = (state_q != LOAD);
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;
endmodule
